// File: rtl/nrz_cdr_pkg.sv
// nrz_cdr_pkg: shared constants and types for the NRZ clock/data recovery
// block. Holds the default loop constants and the phase-region encoding used
// by the phase detector and the NCO.
package nrz_cdr_pkg;

  // Default loop constants for a 32-bit NCO.
  localparam int unsigned     ACC_W_DEF    = 32;
  localparam longint unsigned C_F_DEF      = 64'd14658591;
  localparam longint unsigned KP_DEF       = 64'd1 << 20;
  localparam longint unsigned KI_DEF       = 64'd1;
  localparam int unsigned     LOCK_CNT_DEF = 64;

  // Region of the NCO phase when a data transition is observed.
  // EARLY: phase MSB = 0, LATE: phase MSB = 1.
  typedef enum logic {
    EARLY = 1'b0,
    LATE  = 1'b1
  } phase_region_e;

endpackage

// File: rtl/nrz_cdr_nco.sv
// nrz_cdr_nco: phase accumulator with a clamped integral frequency word.
//
// Ports:
//   clk           in   sampling clock, all logic on posedge
//   rst           in   synchronous active-high reset
//   edge_hit      in   one-cycle pulse: a data transition was seen
//   phase_msbs    out  top two bits of the current phase (region / lock test)
//   phase_nxt_msb out  MSB of the phase value loaded at the next edge
//   freq_word     out  current integral frequency word
//
// Each cycle phase advances by freq_word. On an edge the phase gets a
// one-cycle proportional kick (+KP when late, -KP when early) and the
// frequency word steps by KI in the same direction, clamped to
// [F_MIN, F_MAX].
module nrz_cdr_nco
  import nrz_cdr_pkg::*;
#(
  parameter int unsigned       ACC_W = ACC_W_DEF,
  parameter logic [ACC_W-1:0]  C_F   = ACC_W'(C_F_DEF),
  parameter logic [ACC_W-1:0]  KP    = ACC_W'(KP_DEF),
  parameter logic [ACC_W-1:0]  KI    = ACC_W'(KI_DEF),
  parameter logic [ACC_W-1:0]  F_MIN = C_F - (C_F >> 6),
  parameter logic [ACC_W-1:0]  F_MAX = C_F + (C_F >> 6)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             edge_hit,
  output logic [1:0]       phase_msbs,
  output logic             phase_nxt_msb,
  output logic [ACC_W-1:0] freq_word
);

  logic [ACC_W-1:0] phase_q;
  logic [ACC_W-1:0] freq_q;
  logic [ACC_W-1:0] phase_d;
  logic [ACC_W-1:0] freq_d;
  logic [ACC_W-1:0] corr;
  // One extra bit so the +KI / -KI results can be compared against the
  // bounds without wrapping; bit ACC_W of f_dn flags an underflow.
  logic [ACC_W:0]   f_up;
  logic [ACC_W:0]   f_dn;
  phase_region_e    region;

  assign region = phase_q[ACC_W-1] ? LATE : EARLY;

  always_comb begin
    corr   = '0;
    freq_d = freq_q;
    f_up   = {1'b0, freq_q} + {1'b0, KI};
    f_dn   = {1'b0, freq_q} - {1'b0, KI};
    if (edge_hit) begin
      if (region == LATE) begin
        corr   = KP;
        freq_d = (f_up > {1'b0, F_MAX}) ? F_MAX : f_up[ACC_W-1:0];
      end else begin
        corr   = ACC_W'(0) - KP;
        freq_d = (f_dn[ACC_W] || (f_dn < {1'b0, F_MIN})) ? F_MIN : f_dn[ACC_W-1:0];
      end
    end
    // Uses the frequency word in force this cycle; the stepped word takes
    // effect from the next cycle on.
    phase_d = phase_q + freq_q + corr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      freq_q  <= C_F;
    end else begin
      phase_q <= phase_d;
      freq_q  <= freq_d;
    end
  end

  assign phase_msbs    = phase_q[ACC_W-1 -: 2];
  assign phase_nxt_msb = phase_d[ACC_W-1];
  assign freq_word     = freq_q;

endmodule

// File: rtl/nrz_cdr_pi.sv
// nrz_cdr_pi: bang-bang PI clock/data recovery for an asynchronous NRZ input.
//
// Ports:
//   clk        in   high-frequency sampling clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   nrz        in   asynchronous NRZ serial input
//   cdr_clk    out  recovered bit clock (NCO phase MSB)
//   data_out   out  recovered data bit, held between strobes
//   data_valid out  one-cycle strobe, data_out updated this cycle
//   locked     out  lock indicator
//   freq_word  out  current integral frequency word
//
// Strobe semantics: data_valid is a plain one-cycle qualifier with no
// backpressure; data_out carries the new bit in exactly the cycle
// data_valid is high and holds it until the next strobe.
//
// The NCO phase origin is aimed at data transitions, so the mid-UI sample
// point is the 0->1 transition of the phase MSB. An edge within a quarter UI
// of the origin (top two phase bits equal) counts as good for lock.
module nrz_cdr_pi
  import nrz_cdr_pkg::*;
#(
  parameter int unsigned       ACC_W       = ACC_W_DEF,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [ACC_W-1:0]  C_F         = ACC_W'(C_F_DEF),
  parameter logic [ACC_W-1:0]  KP          = ACC_W'(KP_DEF),
  parameter logic [ACC_W-1:0]  KI          = ACC_W'(KI_DEF),
  parameter logic [ACC_W-1:0]  F_MIN       = C_F - (C_F >> 6),
  parameter logic [ACC_W-1:0]  F_MAX       = C_F + (C_F >> 6),
  parameter int unsigned       LOCK_CNT    = LOCK_CNT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             nrz,
  output logic             cdr_clk,
  output logic             data_out,
  output logic             data_valid,
  output logic             locked,
  output logic [ACC_W-1:0] freq_word
);

  localparam int CNT_W = $clog2(LOCK_CNT + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   sync_d;
  logic                   edge_hit;
  logic [CNT_W-1:0]       lock_cnt;
  logic [1:0]             phase_msbs;
  logic                   phase_nxt_msb;
  logic                   strobe;
  logic                   edge_good;
  logic                   sample_bit;

  assign sync_out = sync_q[SYNC_STAGES-1];

  nrz_cdr_nco #(
    .ACC_W (ACC_W),
    .C_F   (C_F),
    .KP    (KP),
    .KI    (KI),
    .F_MIN (F_MIN),
    .F_MAX (F_MAX)
  ) u_nco (
    .clk           (clk),
    .rst           (rst),
    .edge_hit      (edge_hit),
    .phase_msbs    (phase_msbs),
    .phase_nxt_msb (phase_nxt_msb),
    .freq_word     (freq_word)
  );

  always_comb begin
    strobe     = ~phase_msbs[1] & phase_nxt_msb;
    edge_good  = (phase_msbs[1] == phase_msbs[0]);
    // In an edge cycle sync_d already holds the post-transition level, so
    // the value from before the transition is its complement.
    sample_bit = edge_hit ? ~sync_d : sync_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      sync_d     <= 1'b0;
      edge_hit   <= 1'b0;
      lock_cnt   <= '0;
      data_out   <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], nrz};
      sync_d     <= sync_out;
      edge_hit   <= sync_out ^ sync_d;
      data_valid <= strobe;
      if (strobe) begin
        data_out <= sample_bit;
      end
      if (edge_hit) begin
        if (!edge_good) begin
          lock_cnt <= '0;
        end else if (lock_cnt != CNT_W'(LOCK_CNT)) begin
          lock_cnt <= lock_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign locked  = (lock_cnt == CNT_W'(LOCK_CNT));
  assign cdr_clk = phase_msbs[1];

endmodule
